isp_loader: RTL and testbench
=============================

Name: isp_loader

Overview:
- Parametrised in-system-programming loader.
- Takes the received UART byte stream, packs bytes little-endian into DATA_W-bit words and writes them to program RAM at consecutive word addresses from 0.
- Declares the download complete after a programmable idle timeout; then drives dl_flag to release the core from boot hold.
- Adds over the previous loader: partial-word flush, re-arm, overflow detection, byte count and checksum.

Parameters:
- DATA_W, 32, RAM word width; a multiple of 8, range 8..64. BYTES = DATA_W/8.
- ADDR_W, 16, RAM word-address width; capacity is 2**ADDR_W words.
- TIMEOUT_CYC, 1000000, idle cycles after the last byte that end a download (20 ms at 50 MHz).
- PAD_BYTE, 8'h00, fill value for the unused bytes of a flushed partial word.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- en  in  1  loader enable; high arms the loader, low aborts and clears
- rxdata  in  8  received UART byte
- rx_flag_p  in  1  one-cycle strobe; rxdata valid
- dl_flag  out  1  download complete (sticky until en falls)
- busy  out  1  high in RECV
- err_ovf  out  1  sticky; a byte arrived with RAM full
- write  out  1  one-cycle RAM write strobe
- wraddr  out  ADDR_W  RAM word address
- wrdata  out  DATA_W  RAM write data
- byte_cnt  out  ADDR_W+$clog2(BYTES)+1  bytes accepted
- checksum  out  16  modulo-2^16 sum of accepted bytes

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low. All outputs are registered.
- Reset values: every output, the state register, the packer and the idle counter reset to 0.
- State IDLE:
  - Outputs dl_flag, busy and err_ovf are 0.
  - Address, byte_cnt, checksum and the packer are cleared.
  - en=1 moves to ARMED.
- State ARMED: first rx_flag_p moves to RECV; that byte is accepted.
- State RECV:
  - Each rx_flag_p byte goes into lane k = (byte index mod BYTES), in wrdata bits [8k+7:8k].
  - byte_cnt increments; checksum adds the byte.
  - When lane BYTES-1 fills: write=1 for exactly one cycle, in the cycle after the strobe. wraddr holds the current word address and wrdata holds the packed word.
  - The word address increments after each write.
- Idle counter: cleared on every rx_flag_p; otherwise increments while in RECV.
- Timeout: the counter reaching TIMEOUT_CYC-1 with no strobe that cycle moves to DONE. dl_flag=1 from the next cycle.
  - If a partial word is pending, it is written in that same edge: write=1, unfilled lanes = PAD_BYTE.
- State DONE: ignores rx_flag_p; holds dl_flag=1 and all counters. en=0 returns to IDLE and clears everything.
- Simultaneous strobe and timeout: the strobe wins. The counter clears and no timeout occurs.
- Overflow: a byte arriving when a full word would exceed address 2**ADDR_W-1:
  - sets err_ovf;
  - is dropped and not counted;
  - causes no further writes.
  - The idle timeout still runs, and dl_flag is still asserted.
- en=0 in ARMED or RECV: abort to IDLE next cycle. The partial word is discarded, no flush, dl_flag stays 0.
- Reset mid-operation: all outputs are 0 immediately; no write is issued after reset.
- Throughput: at most one byte per cycle. Back-to-back strobes must be handled with no loss.

Decomposition:
- Package isp_pkg holds:
  - state encodings IDLE/ARMED/RECV/DONE (2-bit);
  - the default timeout constant;
  - a BYTES helper function.
- Sub-module isp_byte_packer handles lane select, the fill count, PAD_BYTE fill on flush, and emits a word-valid pulse.
- isp_loader holds the FSM, idle counter, address, byte_cnt, checksum and overflow logic.

Test Plan:
Bench parameters: DATA_W=32, ADDR_W=4, TIMEOUT_CYC=20 unless stated otherwise.
- Full words: en=1, bytes 01..08 sent back-to-back.
  - write @0 = 0x04030201 and write @1 = 0x08070605, each one cycle.
  - dl_flag=1 twenty-one cycles after the last strobe.
  - byte_cnt=8, checksum=0x0024.
- Partial flush: bytes 01..05.
  - write @0 = 0x04030201.
  - On timeout, write @1 = 0x00000005 in the same cycle as the DONE transition; then dl_flag=1.
- Overflow: ADDR_W=2, 20 bytes sent.
  - Exactly 4 writes at addresses 0..3.
  - err_ovf=1 after the 17th byte; byte_cnt=16; dl_flag=1 after the timeout.
- Abort and re-arm: 3 bytes, then en=0 for 1 cycle.
  - No write; dl_flag=0; byte_cnt=0.
  - After en=1 and bytes AA BB CC DD: write @0 = 0xDDCCBBAA.
- Boundary: strobes spaced exactly 19 idle cycles apart, then one byte on the timeout cycle.
  - No DONE; packing continues; dl_flag=0.
- Reset mid-word: rst_n low after 2 bytes.
  - All outputs are 0 asynchronously; no write follows.
  - After release and re-arm, the address restarts at 0.

Source files
------------

// File: rtl/isp_pkg.sv
// Shared definitions for the in-system-programming loader: FSM encoding,
// default idle timeout and the bytes-per-word helper.
package isp_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        RECV  = 2'd2,
        DONE  = 2'd3
    } state_e;

    // 20 ms of silence at 50 MHz ends a download.
    localparam int DEFAULT_TIMEOUT_CYC = 1000000;

    function automatic int bytes_per_word(input int data_w);
        return data_w / 8;
    endfunction

endpackage

// File: rtl/isp_byte_packer.sv
// Packs a byte stream little-endian into words; emits a word-valid pulse when the
// last lane fills or when a pending partial word is flushed with PAD_BYTE fill.
module isp_byte_packer
    import isp_pkg::*;
#(
    parameter int         DATA_W   = 32,
    parameter logic [7:0] PAD_BYTE = 8'h00
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr_i,
    input  logic              byte_valid_i,
    input  logic [7:0]        byte_i,
    input  logic              flush_i,
    output logic              word_valid_o,
    output logic [DATA_W-1:0] word_o
);

    localparam int BYTES  = bytes_per_word(DATA_W);
    localparam int LANE_W = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(BYTES - 1);

    logic [LANE_W-1:0] lane_q;
    logic [DATA_W-1:0] word_q;
    logic              last_lane;
    logic              pending;

    assign last_lane    = (lane_q == LAST_LANE);
    assign pending      = (lane_q != '0);
    assign word_valid_o = byte_valid_i ? last_lane : (flush_i && pending);

    // Output word merges stored lanes, the incoming byte and padding for the rest.
    genvar gi;
    generate
        for (gi = 0; gi < BYTES; gi++) begin : g_lane
            assign word_o[8*gi +: 8] =
                (byte_valid_i && (lane_q == LANE_W'(gi))) ? byte_i :
                (LANE_W'(gi) < lane_q)                    ? word_q[8*gi +: 8] :
                                                            PAD_BYTE;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lane_q <= '0;
            word_q <= '0;
        end else if (clr_i) begin
            lane_q <= '0;
            word_q <= '0;
        end else if (byte_valid_i) begin
            word_q[{lane_q, 3'b000} +: 8] <= byte_i;
            lane_q <= last_lane ? '0 : lane_q + LANE_W'(1);
        end else if (flush_i) begin
            lane_q <= '0;
        end
    end

endmodule

// File: rtl/isp_loader.sv
// UART-fed program RAM loader: packs bytes into words, writes them from address 0,
// and raises dl_flag after an idle timeout. Tracks overflow, byte count and checksum.
module isp_loader
    import isp_pkg::*;
#(
    parameter int         DATA_W      = 32,
    parameter int         ADDR_W      = 16,
    parameter int         TIMEOUT_CYC = DEFAULT_TIMEOUT_CYC,
    parameter logic [7:0] PAD_BYTE    = 8'h00
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               en,
    input  logic [7:0]                         rxdata,
    input  logic                               rx_flag_p,
    output logic                               dl_flag,
    output logic                               busy,
    output logic                               err_ovf,
    output logic                               write,
    output logic [ADDR_W-1:0]                  wraddr,
    output logic [DATA_W-1:0]                  wrdata,
    output logic [ADDR_W+$clog2(DATA_W/8):0]   byte_cnt,
    output logic [15:0]                        checksum
);

    localparam int BYTES  = bytes_per_word(DATA_W);
    localparam int CNT_W  = ADDR_W + $clog2(BYTES) + 1;
    localparam int IDLE_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CNT_W-1:0]  CAPACITY  = CNT_W'(BYTES) << ADDR_W;
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT_CYC - 1);

    state_e              state_q;
    logic [IDLE_W-1:0]   idle_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [ADDR_W-1:0]   wraddr_q;
    logic [DATA_W-1:0]   wrdata_q;
    logic [CNT_W-1:0]    byte_cnt_q;
    logic [15:0]         checksum_q;
    logic                dl_flag_q;
    logic                busy_q;
    logic                err_ovf_q;
    logic                write_q;

    logic                in_rx;
    logic                ram_full;
    logic                accept;
    logic                timeout;
    logic                clr;
    logic                word_valid;
    logic [DATA_W-1:0]   word;

    // RAM is full exactly when every byte slot has been accepted.
    assign in_rx    = (state_q == ARMED) || (state_q == RECV);
    assign ram_full = (byte_cnt_q == CAPACITY);
    assign accept   = en && in_rx && rx_flag_p && !ram_full;
    assign timeout  = en && (state_q == RECV) && !rx_flag_p && (idle_q == IDLE_LAST);
    assign clr      = !en || (state_q == IDLE);

    isp_byte_packer #(
        .DATA_W   (DATA_W),
        .PAD_BYTE (PAD_BYTE)
    ) u_packer (
        .clk          (clk),
        .rst_n        (rst_n),
        .clr_i        (clr),
        .byte_valid_i (accept),
        .byte_i       (rxdata),
        .flush_i      (timeout),
        .word_valid_o (word_valid),
        .word_o       (word)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            idle_q     <= '0;
            addr_q     <= '0;
            wraddr_q   <= '0;
            wrdata_q   <= '0;
            byte_cnt_q <= '0;
            checksum_q <= '0;
            dl_flag_q  <= 1'b0;
            busy_q     <= 1'b0;
            err_ovf_q  <= 1'b0;
            write_q    <= 1'b0;
        end else begin
            write_q <= 1'b0;
            if (clr) begin
                // Dropping en aborts from any state; a partial word is discarded.
                state_q    <= en ? ARMED : IDLE;
                idle_q     <= '0;
                addr_q     <= '0;
                wraddr_q   <= '0;
                wrdata_q   <= '0;
                byte_cnt_q <= '0;
                checksum_q <= '0;
                dl_flag_q  <= 1'b0;
                busy_q     <= 1'b0;
                err_ovf_q  <= 1'b0;
            end else begin
                case (state_q)
                    ARMED: begin
                        if (rx_flag_p) begin
                            state_q <= RECV;
                            busy_q  <= 1'b1;
                            idle_q  <= '0;
                        end
                    end
                    RECV: begin
                        if (rx_flag_p) begin
                            idle_q <= '0;
                        end else if (timeout) begin
                            state_q <= DONE;
                            busy_q  <= 1'b0;
                        end else begin
                            idle_q <= idle_q + IDLE_W'(1);
                        end
                    end
                    DONE:    dl_flag_q <= 1'b1;
                    default: ;
                endcase

                if (accept) begin
                    byte_cnt_q <= byte_cnt_q + CNT_W'(1);
                    checksum_q <= checksum_q + {8'h00, rxdata};
                end
                if (in_rx && rx_flag_p && ram_full) begin
                    err_ovf_q <= 1'b1;
                end
                if (word_valid) begin
                    write_q  <= 1'b1;
                    wraddr_q <= addr_q;
                    wrdata_q <= word;
                    addr_q   <= addr_q + ADDR_W'(1);
                end
            end
        end
    end

    assign dl_flag  = dl_flag_q;
    assign busy     = busy_q;
    assign err_ovf  = err_ovf_q;
    assign write    = write_q;
    assign wraddr   = wraddr_q;
    assign wrdata   = wrdata_q;
    assign byte_cnt = byte_cnt_q;
    assign checksum = checksum_q;

endmodule

// File: tb/tb_isp_loader.sv
// Bench for isp_loader: random and directed byte streams compared with a
// word-packing reference model built from the byte list.
`timescale 1ns/1ps
module tb_isp_loader;

    typedef logic [7:0] u8_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        en = 1'b0;
    logic        en2 = 1'b0;
    logic        rx_flag_p = 1'b0;
    logic [7:0]  rxdata = 8'h00;

    logic        dl_flag, busy, err_ovf, write;
    logic [3:0]  wraddr;
    logic [31:0] wrdata;
    logic [6:0]  byte_cnt;
    logic [15:0] checksum;

    logic        dl_flag2, busy2, err_ovf2, write2;
    logic [1:0]  wraddr2;
    logic [31:0] wrdata2;
    logic [4:0]  byte_cnt2;
    logic [15:0] checksum2;

    isp_loader #(.DATA_W(32), .ADDR_W(4), .TIMEOUT_CYC(20), .PAD_BYTE(8'h00)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .rxdata(rxdata), .rx_flag_p(rx_flag_p),
        .dl_flag(dl_flag), .busy(busy), .err_ovf(err_ovf), .write(write),
        .wraddr(wraddr), .wrdata(wrdata), .byte_cnt(byte_cnt), .checksum(checksum)
    );

    isp_loader #(.DATA_W(32), .ADDR_W(2), .TIMEOUT_CYC(20), .PAD_BYTE(8'h00)) dut_ovf (
        .clk(clk), .rst_n(rst_n), .en(en2), .rxdata(rxdata), .rx_flag_p(rx_flag_p),
        .dl_flag(dl_flag2), .busy(busy2), .err_ovf(err_ovf2), .write(write2),
        .wraddr(wraddr2), .wrdata(wrdata2), .byte_cnt(byte_cnt2), .checksum(checksum2)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int fails = 0;
    int last_edge = 0;

    int          wr_addr[$];
    logic [31:0] wr_data[$];
    int          wr_cyc[$];
    int          wr_long = 0;
    logic        write_prev = 1'b0;
    int          wr2_addr[$];
    logic [31:0] wr2_data[$];

    int          exp_addr[$];
    logic [31:0] exp_data[$];
    int          exp_cnt;
    logic [15:0] exp_sum;

    always @(negedge clk) begin
        if (write === 1'b1) begin
            wr_addr.push_back(int'(wraddr));
            wr_data.push_back(wrdata);
            wr_cyc.push_back(cyc);
            if (write_prev === 1'b1) wr_long++;
            $display("t=%0t dut write @%0d = %08h", $time, wraddr, wrdata);
        end
        write_prev = write;
        if (write2 === 1'b1) begin
            wr2_addr.push_back(int'(wraddr2));
            wr2_data.push_back(wrdata2);
            $display("t=%0t dut_ovf write @%0d = %08h", $time, wraddr2, wrdata2);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus helpers (no checking) ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic arm(input bit which);
        if (which) en2 = 1'b1;
        else en = 1'b1;
        step();
        step();
    endtask

    task automatic disarm();
        en = 1'b0;
        en2 = 1'b0;
        step();
    endtask

    task automatic clear_mon();
        wr_addr.delete();
        wr_data.delete();
        wr_cyc.delete();
        wr2_addr.delete();
        wr2_data.delete();
        wr_long = 0;
    endtask

    // gap < 0 selects a random idle gap of 0..4 cycles between bytes.
    task automatic send_stream(input u8_t bs[$], input int gap);
        for (int i = 0; i < bs.size(); i++) begin
            rxdata = bs[i];
            rx_flag_p = 1'b1;
            step();
            rx_flag_p = 1'b0;
            last_edge = cyc;
            if (i != bs.size() - 1) repeat ((gap < 0) ? $urandom_range(0, 4) : gap) step();
        end
    endtask

    task automatic wait_dl(input bit which, output int lat);
        lat = -1;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if ((which ? dl_flag2 : dl_flag) === 1'b1) begin
                lat = cyc - last_edge;
                break;
            end
        end
    endtask

    // Reference: accepted bytes are the first cap_bytes; word w holds bytes 4w..4w+3,
    // little-endian, with missing bytes of the final word padded with 0x00.
    task automatic build_model(input u8_t bs[$], input int cap_bytes);
        int acc;
        logic [31:0] w32;
        acc = (bs.size() < cap_bytes) ? bs.size() : cap_bytes;
        exp_cnt = acc;
        exp_sum = 16'h0000;
        exp_addr.delete();
        exp_data.delete();
        for (int i = 0; i < acc; i++) exp_sum = exp_sum + 16'(bs[i]);
        for (int w = 0; w * 4 < acc; w++) begin
            w32 = 32'h0;
            for (int k = 0; k < 4; k++)
                if (w * 4 + k < acc) w32 = w32 | (32'(bs[w * 4 + k]) << (8 * k));
            exp_addr.push_back(w);
            exp_data.push_back(w32);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        #2 rst_n = 1'b0;
        en = 1'b1;
        en2 = 1'b1;
        rxdata = 8'hFF;
        rx_flag_p = 1'b1;
        repeat (3) step();
        checks++;
        if ({dl_flag, busy, err_ovf, write, wraddr, wrdata, byte_cnt, checksum} !== '0) begin
            fails++;
            $display("FAIL reset_dut: got dl=%b busy=%b ovf=%b wr=%b cnt=%0d sum=%h required all 0",
                     dl_flag, busy, err_ovf, write, byte_cnt, checksum);
        end
        checks++;
        if ({dl_flag2, busy2, err_ovf2, write2, wraddr2, wrdata2, byte_cnt2, checksum2} !== '0) begin
            fails++;
            $display("FAIL reset_dut_ovf: got dl=%b busy=%b ovf=%b wr=%b cnt=%0d required all 0",
                     dl_flag2, busy2, err_ovf2, write2, byte_cnt2);
        end
        rx_flag_p = 1'b0;
        en = 1'b0;
        en2 = 1'b0;
        rst_n = 1'b1;
        step();
        step();
    endtask

    task automatic test_full_words();
        u8_t bs[$];
        int lat;
        clear_mon();
        arm(0);
        for (int i = 1; i <= 8; i++) bs.push_back(u8_t'(i));
        build_model(bs, 64);
        send_stream(bs, 0);
        wait_dl(0, lat);
        checks++;
        if (lat !== 21) begin fails++; $display("FAIL full_words dl latency: got %0d required 21", lat); end
        checks++;
        if (wr_data.size() !== exp_data.size()) begin
            fails++; $display("FAIL full_words write count: got %0d required %0d", wr_data.size(), exp_data.size());
        end
        for (int i = 0; i < exp_data.size() && i < wr_data.size(); i++) begin
            checks++;
            if (wr_addr[i] !== exp_addr[i] || wr_data[i] !== exp_data[i]) begin
                fails++; $display("FAIL full_words write %0d: got @%0d=%08h required @%0d=%08h",
                                  i, wr_addr[i], wr_data[i], exp_addr[i], exp_data[i]);
            end
        end
        checks++;
        if (int'(byte_cnt) !== 8) begin fails++; $display("FAIL full_words byte_cnt: got %0d required 8", byte_cnt); end
        checks++;
        if (checksum !== 16'h0024) begin fails++; $display("FAIL full_words checksum: got %h required 0024", checksum); end
        checks++;
        if (wr_long !== 0) begin fails++; $display("FAIL full_words write pulse width: got %0d long pulses required 0", wr_long); end
        checks++;
        if (err_ovf !== 1'b0) begin fails++; $display("FAIL full_words err_ovf: got %b required 0", err_ovf); end
        step();
        disarm();
    endtask

    task automatic test_partial_flush();
        u8_t bs[$];
        int lat;
        clear_mon();
        arm(0);
        for (int i = 1; i <= 5; i++) bs.push_back(u8_t'(i));
        build_model(bs, 64);
        send_stream(bs, 0);
        wait_dl(0, lat);
        checks++;
        if (lat !== 21) begin fails++; $display("FAIL partial dl latency: got %0d required 21", lat); end
        checks++;
        if (wr_data.size() !== 2) begin fails++; $display("FAIL partial write count: got %0d required 2", wr_data.size()); end
        for (int i = 0; i < exp_data.size() && i < wr_data.size(); i++) begin
            checks++;
            if (wr_addr[i] !== exp_addr[i] || wr_data[i] !== exp_data[i]) begin
                fails++; $display("FAIL partial write %0d: got @%0d=%08h required @%0d=%08h",
                                  i, wr_addr[i], wr_data[i], exp_addr[i], exp_data[i]);
            end
        end
        checks++;
        if (wr_cyc.size() < 2 || wr_cyc[1] !== last_edge + 20) begin
            fails++; $display("FAIL partial flush timing: got cycle %0d required %0d",
                              (wr_cyc.size() < 2) ? -1 : wr_cyc[1], last_edge + 20);
        end
        step();
        disarm();
    endtask

    task automatic test_overflow();
        u8_t bs[$];
        int lat;
        clear_mon();
        arm(1);
        for (int i = 0; i < 20; i++) bs.push_back(u8_t'($urandom_range(0, 255)));
        build_model(bs, 16);
        for (int i = 0; i < 20; i++) begin
            rxdata = bs[i];
            rx_flag_p = 1'b1;
            step();
            rx_flag_p = 1'b0;
            last_edge = cyc;
            checks++;
            if (err_ovf2 !== (i >= 16)) begin
                fails++; $display("FAIL overflow err_ovf after byte %0d: got %b required %b", i + 1, err_ovf2, (i >= 16));
            end
        end
        wait_dl(1, lat);
        checks++;
        if (lat !== 21) begin fails++; $display("FAIL overflow dl latency: got %0d required 21", lat); end
        checks++;
        if (wr2_data.size() !== 4) begin fails++; $display("FAIL overflow write count: got %0d required 4", wr2_data.size()); end
        for (int i = 0; i < exp_data.size() && i < wr2_data.size(); i++) begin
            checks++;
            if (wr2_addr[i] !== exp_addr[i] || wr2_data[i] !== exp_data[i]) begin
                fails++; $display("FAIL overflow write %0d: got @%0d=%08h required @%0d=%08h",
                                  i, wr2_addr[i], wr2_data[i], exp_addr[i], exp_data[i]);
            end
        end
        checks++;
        if (int'(byte_cnt2) !== 16) begin fails++; $display("FAIL overflow byte_cnt: got %0d required 16", byte_cnt2); end
        checks++;
        if (checksum2 !== exp_sum) begin fails++; $display("FAIL overflow checksum: got %h required %h", checksum2, exp_sum); end
        step();
        disarm();
    endtask

    task automatic test_abort_rearm();
        u8_t bs[$];
        int lat;
        clear_mon();
        arm(0);
        bs = '{8'h11, 8'h22, 8'h33};
        send_stream(bs, 0);
        en = 1'b0;
        step();
        en = 1'b1;
        repeat (25) step();
        checks++;
        if (wr_data.size() !== 0) begin fails++; $display("FAIL abort write count: got %0d required 0", wr_data.size()); end
        checks++;
        if (dl_flag !== 1'b0) begin fails++; $display("FAIL abort dl_flag: got %b required 0", dl_flag); end
        checks++;
        if (int'(byte_cnt) !== 0) begin fails++; $display("FAIL abort byte_cnt: got %0d required 0", byte_cnt); end
        bs = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
        build_model(bs, 64);
        send_stream(bs, 0);
        step();
        checks++;
        if (wr_data.size() !== 1 || wr_addr[0] !== 0 || wr_data[0] !== 32'hDDCCBBAA) begin
            fails++; $display("FAIL rearm write: got %0d writes, first %08h required @0=ddccbbaa",
                              wr_data.size(), (wr_data.size() > 0) ? wr_data[0] : 32'h0);
        end
        wait_dl(0, lat);
        checks++;
        if (checksum !== exp_sum) begin fails++; $display("FAIL rearm checksum: got %h required %h", checksum, exp_sum); end
        step();
        disarm();
    endtask

    task automatic test_boundary();
        u8_t bs[$];
        int lat;
        clear_mon();
        arm(0);
        for (int i = 0; i < 6; i++) bs.push_back(u8_t'($urandom_range(0, 255)));
        build_model(bs, 64);
        for (int i = 0; i < 6; i++) begin
            rxdata = bs[i];
            rx_flag_p = 1'b1;
            step();
            rx_flag_p = 1'b0;
            last_edge = cyc;
            if (i != 5) begin
                repeat (19) step();
                checks++;
                if (dl_flag !== 1'b0 || busy !== 1'b1) begin
                    fails++; $display("FAIL boundary before byte %0d: got dl=%b busy=%b required dl=0 busy=1",
                                      i + 2, dl_flag, busy);
                end
            end
        end
        wait_dl(0, lat);
        checks++;
        if (lat !== 21) begin fails++; $display("FAIL boundary dl latency: got %0d required 21", lat); end
        checks++;
        if (wr_data.size() !== exp_data.size()) begin
            fails++; $display("FAIL boundary write count: got %0d required %0d", wr_data.size(), exp_data.size());
        end
        for (int i = 0; i < exp_data.size() && i < wr_data.size(); i++) begin
            checks++;
            if (wr_addr[i] !== exp_addr[i] || wr_data[i] !== exp_data[i]) begin
                fails++; $display("FAIL boundary write %0d: got @%0d=%08h required @%0d=%08h",
                                  i, wr_addr[i], wr_data[i], exp_addr[i], exp_data[i]);
            end
        end
        checks++;
        if (int'(byte_cnt) !== 6) begin fails++; $display("FAIL boundary byte_cnt: got %0d required 6", byte_cnt); end
        step();
        disarm();
    endtask

    task automatic test_random();
        u8_t bs[$];
        int lat;
        for (int it = 0; it < 3; it++) begin
            bs.delete();
            clear_mon();
            arm(0);
            for (int i = 0; i < int'($urandom_range(1, 40)); i++) bs.push_back(u8_t'($urandom_range(0, 255)));
            build_model(bs, 64);
            send_stream(bs, -1);
            wait_dl(0, lat);
            checks++;
            if (lat !== 21) begin fails++; $display("FAIL random[%0d] dl latency: got %0d required 21", it, lat); end
            checks++;
            if (wr_data.size() !== exp_data.size()) begin
                fails++; $display("FAIL random[%0d] write count: got %0d required %0d", it, wr_data.size(), exp_data.size());
            end
            for (int i = 0; i < exp_data.size() && i < wr_data.size(); i++) begin
                checks++;
                if (wr_addr[i] !== exp_addr[i] || wr_data[i] !== exp_data[i]) begin
                    fails++; $display("FAIL random[%0d] write %0d: got @%0d=%08h required @%0d=%08h",
                                      it, i, wr_addr[i], wr_data[i], exp_addr[i], exp_data[i]);
                end
            end
            checks++;
            if (int'(byte_cnt) !== exp_cnt || checksum !== exp_sum) begin
                fails++; $display("FAIL random[%0d] counters: got cnt=%0d sum=%h required cnt=%0d sum=%h",
                                  it, byte_cnt, checksum, exp_cnt, exp_sum);
            end
            step();
            disarm();
        end
    endtask

    task automatic test_reset_mid();
        u8_t bs[$];
        int lat;
        clear_mon();
        arm(0);
        bs = '{8'h5A, 8'hC3};
        send_stream(bs, 0);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({dl_flag, busy, err_ovf, write, wraddr, wrdata, byte_cnt, checksum} !== '0) begin
            fails++; $display("FAIL reset_mid async clear: got busy=%b cnt=%0d sum=%h required all 0",
                              busy, byte_cnt, checksum);
        end
        repeat (3) step();
        rst_n = 1'b1;
        repeat (25) step();
        checks++;
        if (wr_data.size() !== 0) begin fails++; $display("FAIL reset_mid stray write: got %0d writes required 0", wr_data.size()); end
        bs = '{8'h10, 8'h20, 8'h30, 8'h40};
        send_stream(bs, 0);
        step();
        checks++;
        if (wr_data.size() !== 1 || wr_addr[0] !== 0 || wr_data[0] !== 32'h40302010) begin
            fails++; $display("FAIL reset_mid rearm write: got %0d writes, first @%0d required @0=40302010",
                              wr_data.size(), (wr_addr.size() > 0) ? wr_addr[0] : -1);
        end
        wait_dl(0, lat);
        step();
        disarm();
    endtask

    initial begin
        test_reset();
        test_full_words();
        test_partial_flush();
        test_overflow();
        test_abort_rearm();
        test_boundary();
        test_random();
        test_reset_mid();
        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
